fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Fetch stage plus IF/ID register for the 5-stage ARM pipeline. It sits directly upstream of the decode controller and supplies InstrD.
- Holds PCF and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned words in a small prefetch FIFO.
- Handles branch/PC-write redirects, stalls and decode flushes.

Parameters:
PC_RESET, 32'h00000000, PCF value after reset
DEPTH, 2, prefetch FIFO entries (power of 2, >=2)
NOP_INSTR, 32'hE1A00000, bubble word (MOV r0,r0) loaded into InstrD

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  response valid; imem_rdata is sampled in this cycle
imem_rdata  in  32  instruction word
StallF  in  1  block issue of new requests
StallD  in  1  hold IF/ID register
FlushD  in  1  load bubble into IF/ID register
PCWrPendingF  in  1  PC write in flight; block new requests
BranchTakenD  in  1  early branch redirect
BranchTargetD  in  32  branch target
PCSrcW  in  1  writeback PC redirect
ResultW  in  32  writeback PC value
InstrD  out  32  decode-stage instruction
PCPlus8D  out  32  PC of InstrD + 8 (r15 read value)
ValidD  out  1  InstrD is a real fetched instruction

Behaviour:
- Reset (asynchronous, active-high) values:
  - PCF=PC_RESET; FIFO empty; no request outstanding; drop flag 0.
  - imem_req=0, InstrD=NOP_INSTR, PCPlus8D=PC_RESET+8, ValidD=0.
- Request issue:
  - imem_req=1 when all hold: no request outstanding, count+pending < DEPTH, ~StallF, ~PCWrPendingF, no redirect this cycle.
  - imem_addr=PCF.
  - Once issued, imem_req and imem_addr stay stable until imem_ack. imem_ack may arrive in the issue cycle or any later cycle.
- Response:
  - On imem_ack with drop=0: push {imem_rdata, PCF}, then PCF<=PCF+4. PCF wraps modulo 2^32.
  - On imem_ack with drop=1: discard the data, clear drop, leave PCF unchanged.
- Redirect target: PCSrcW takes priority over BranchTakenD. Target is ResultW if PCSrcW, else BranchTargetD, with bits[1:0] forced to 0.
- Redirect cycle actions:
  - FIFO cleared.
  - PCF<=target.
  - If a request is outstanding and not acked this cycle, drop<=1.
  - An ack in the same cycle is discarded.
  - Next request issues no earlier than the following cycle.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD=NOP_INSTR, ValidD=0. No FIFO pop. PCPlus8D is held.
  - StallD: all decode outputs hold; no pop.
  - Otherwise, FIFO non-empty: pop head; InstrD=word, PCPlus8D=pc+8, ValidD=1.
  - Otherwise, FIFO empty: bubble (NOP_INSTR, ValidD=0). No bypass from imem_rdata to InstrD; minimum fetch-to-decode latency is 1 cycle after ack.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits plus a count.
  - Push and pop in the same cycle keep count unchanged.
  - Overflow cannot occur because issue is gated on count+pending.
  - Pop while empty is impossible by construction.
- StallF blocks issue only; an already outstanding response is still accepted and pushed.
- A redirect during StallD still clears the FIFO, while the IF/ID register holds.

Optional Feature:
Macro: FETCH_PERF_EN
- Defined: adds output ports perf_redirects (16 bits) and perf_bubbles (16 bits).
  - perf_redirects increments on each redirect cycle.
  - perf_bubbles increments on each cycle an empty-FIFO bubble is loaded (not on FlushD).
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Zero-wait memory (ack in issue cycle), no stalls, memory returns words 0xA0..: InstrD yields successive words, PCPlus8D=8,12,16..., ValidD=1 after the first bubble.
- Ack latency 3 cycles: imem_addr is held stable for 3 cycles; InstrD shows NOP_INSTR/ValidD=0 between instructions; at most 1 request is outstanding.
- StallD held 5 cycles with fast memory: FIFO fills to DEPTH, imem_req drops, InstrD is unchanged; on release, the instructions are delivered in order with no loss or duplication.
- BranchTakenD with BranchTargetD=0x100 while a request to 0x10 is outstanding: the 0x10 response is discarded, the next imem_addr=0x100, and the first valid InstrD after the redirect has PCPlus8D=0x108.
- PCSrcW (ResultW=0x200) and BranchTakenD (0x100) in the same cycle: the next request is to 0x200.
- FlushD and StallD asserted together: InstrD=NOP_INSTR, ValidD=0, FIFO count unchanged.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage + IF/ID register: single-outstanding imem requests, prefetch FIFO, redirect/stall/flush handling.
// Latency: InstrD loads one cycle after imem_ack at the earliest (no rdata bypass). Optional counters: FETCH_PERF_EN.
// Backpressure: issue gated by StallF/PCWrPendingF/FIFO occupancy; StallD holds IF/ID and stops FIFO pops.
module fetch_prefetch_unit #(
   parameter logic [31:0] PC_RESET  = 32'h00000000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCWrPendingF,
   input  logic        BranchTakenD,
   input  logic [31:0] BranchTargetD,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus8D,
`ifdef FETCH_PERF_EN
   output logic [15:0] perf_redirects,
   output logic [15:0] perf_bubbles,
`endif
   output logic        ValidD
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetchEntry_t;

   fetchEntry_t      fifoMem [DEPTH];
   fetchEntry_t      head;
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [CNT_W-1:0] count;
   logic [31:0]      pcF, reqAddr, redirectTarget;
   logic             pending, dropFlag;
   logic             redirect, issue, reqInt, ackSeen;
   logic             pushEn, popEn, loadD, fifoEmpty;

   assign redirect       = PCSrcW | BranchTakenD;
   assign redirectTarget = (PCSrcW ? ResultW : BranchTargetD) & ~32'h3;

   // pending already excludes a second request, so count alone bounds occupancy
   assign issue     = ~pending & (count < DEPTH_CNT) & ~StallF & ~PCWrPendingF & ~redirect;
   assign reqInt    = pending | issue;
   assign imem_req  = reqInt & ~reset;
   assign imem_addr = pending ? reqAddr : pcF;
   assign ackSeen   = imem_ack & reqInt;

   assign fifoEmpty = (count == '0);
   assign loadD     = ~FlushD & ~StallD;
   assign pushEn    = ackSeen & ~dropFlag & ~redirect;
   assign popEn     = loadD & ~fifoEmpty;
   assign head      = fifoMem[rdPtr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcF      <= PC_RESET;
         reqAddr  <= PC_RESET;
         pending  <= 1'b0;
         dropFlag <= 1'b0;
      end else begin
         pending <= reqInt & ~imem_ack;
         if (issue)
            reqAddr <= pcF;
         if (redirect) begin
            pcF      <= redirectTarget;
            // the in-flight response belongs to the old stream and must be thrown away
            dropFlag <= pending & ~imem_ack;
         end else if (ackSeen) begin
            if (dropFlag)
               dropFlag <= 1'b0;
            else
               pcF <= pcF + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn)
         fifoMem[wrPtr] <= '{instr: imem_rdata, pc: pcF};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (redirect) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushEn)
            wrPtr <= wrPtr + PTR_W'(1);
         if (popEn)
            rdPtr <= rdPtr + PTR_W'(1);
         case ({pushEn, popEn})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         InstrD   <= NOP_INSTR;
         PCPlus8D <= PC_RESET + 32'd8;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (!fifoEmpty) begin
            InstrD   <= head.instr;
            PCPlus8D <= head.pc + 32'd8;
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic bubbleD;
   assign bubbleD = loadD & fifoEmpty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_redirects <= '0;
         perf_bubbles   <= '0;
      end else begin
         if (redirect && perf_redirects != 16'hFFFF)
            perf_redirects <= perf_redirects + 16'd1;
         if (bubbleD && perf_bubbles != 16'hFFFF)
            perf_bubbles <= perf_bubbles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: vector table on zero-wait memory plus latency/redirect sequences.
module tb_fetch_prefetch_unit;

   localparam logic [31:0] NOP = 32'hE1A00000;
   localparam int NV = 22;

   logic        clk, reset;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        StallF, StallD, FlushD, PCWrPendingF, BranchTakenD, PCSrcW;
   logic [31:0] BranchTargetD, ResultW;
   logic [31:0] InstrD, PCPlus8D;
   logic        ValidD;

   logic [31:0] lat, waitCnt;
   int checks, errors;

   typedef struct {
      logic        sF, sD, fD, pw;
      logic        eReq;
      logic [31:0] eAddr, eInstr, ePc8;
      logic        eV;
   } vec_t;
   vec_t vecs [NV];

   fetch_prefetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCWrPendingF(PCWrPendingF),
      .BranchTakenD(BranchTakenD), .BranchTargetD(BranchTargetD),
      .PCSrcW(PCSrcW), .ResultW(ResultW),
      .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: ack after 'lat' waiting cycles, word = 0xA0 + word index
   assign imem_ack   = imem_req && (waitCnt == lat);
   assign imem_rdata = 32'hA0 + {2'b00, imem_addr[31:2]};

   always @(posedge clk or posedge reset) begin
      if (reset)
         waitCnt <= 32'd0;
      else if (imem_req && !imem_ack)
         waitCnt <= waitCnt + 32'd1;
      else
         waitCnt <= 32'd0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic setv(input int i, input logic [3:0] ctl, input logic er, input logic [31:0] ea,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev);
      vecs[i].sF = ctl[3]; vecs[i].sD = ctl[2]; vecs[i].fD = ctl[1]; vecs[i].pw = ctl[0];
      vecs[i].eReq = er; vecs[i].eAddr = ea; vecs[i].eInstr = ei; vecs[i].ePc8 = ep; vecs[i].eV = ev;
   endtask

   task automatic clearInputs();
      StallF = 0; StallD = 0; FlushD = 0; PCWrPendingF = 0;
      BranchTakenD = 0; BranchTargetD = 0; PCSrcW = 0; ResultW = 0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        prevWait, found, got;
      logic [31:0] prevAddr;
      int          n;

      checks = 0; errors = 0;
      lat = 32'd0;
      clearInputs();

      // ctl = {StallF, StallD, FlushD, PCWrPendingF}
      setv(0,  4'b0000, 1, 32'h00, NOP,   32'h08, 0);
      setv(1,  4'b0000, 1, 32'h04, 32'hA0, 32'h08, 1);
      setv(2,  4'b0000, 1, 32'h08, 32'hA1, 32'h0C, 1);
      setv(3,  4'b0000, 1, 32'h0C, 32'hA2, 32'h10, 1);
      setv(4,  4'b0100, 1, 32'h10, 32'hA2, 32'h10, 1);
      setv(5,  4'b0100, 0, 32'h00, 32'hA2, 32'h10, 1);
      setv(6,  4'b0100, 0, 32'h00, 32'hA2, 32'h10, 1);
      setv(7,  4'b0100, 0, 32'h00, 32'hA2, 32'h10, 1);
      setv(8,  4'b0100, 0, 32'h00, 32'hA2, 32'h10, 1);
      setv(9,  4'b0000, 0, 32'h00, 32'hA3, 32'h14, 1);
      setv(10, 4'b0000, 1, 32'h14, 32'hA4, 32'h18, 1);
      setv(11, 4'b0000, 1, 32'h18, 32'hA5, 32'h1C, 1);
      setv(12, 4'b1110, 0, 32'h00, NOP,   32'h1C, 0);
      setv(13, 4'b1000, 0, 32'h00, 32'hA6, 32'h20, 1);
      setv(14, 4'b1000, 0, 32'h00, NOP,   32'h20, 0);
      setv(15, 4'b0000, 1, 32'h1C, NOP,   32'h20, 0);
      setv(16, 4'b0000, 1, 32'h20, 32'hA7, 32'h24, 1);
      setv(17, 4'b0010, 1, 32'h24, NOP,   32'h24, 0);
      setv(18, 4'b0000, 0, 32'h00, 32'hA8, 32'h28, 1);
      setv(19, 4'b0000, 1, 32'h28, 32'hA9, 32'h2C, 1);
      setv(20, 4'b0001, 0, 32'h00, 32'hAA, 32'h30, 1);
      setv(21, 4'b0000, 1, 32'h2C, NOP,   32'h30, 0);

      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset imem_req", {31'b0, imem_req}, 32'd0);
      chk("reset InstrD", InstrD, NOP);
      chk("reset PCPlus8D", PCPlus8D, 32'h8);
      chk("reset ValidD", {31'b0, ValidD}, 32'd0);
      reset = 1'b0;

      // zero-wait memory vector table
      for (int i = 0; i < NV; i++) begin
         StallF = vecs[i].sF; StallD = vecs[i].sD; FlushD = vecs[i].fD; PCWrPendingF = vecs[i].pw;
         #1;
         chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].eReq});
         if (vecs[i].eReq)
            chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eAddr);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("row%0d InstrD", i), InstrD, vecs[i].eInstr);
         chk($sformatf("row%0d PCPlus8D", i), PCPlus8D, vecs[i].ePc8);
         chk($sformatf("row%0d ValidD", i), {31'b0, ValidD}, {31'b0, vecs[i].eV});
      end

      // ack latency 3: address held, bubbles between instructions, one valid every 4 cycles
      clearInputs();
      lat = 32'd3;
      doReset();
      prevWait = imem_req && !imem_ack;
      prevAddr = imem_addr;
      chk("lat first addr", imem_addr, 32'h0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (prevWait) begin
            chk($sformatf("lat c%0d req held", i), {31'b0, imem_req}, 32'd1);
            chk($sformatf("lat c%0d addr held", i), imem_addr, prevAddr);
         end
         prevWait = imem_req && !imem_ack;
         prevAddr = imem_addr;
         if (i >= 5 && ((i - 5) % 4) == 0) begin
            n = (i - 5) / 4;
            chk($sformatf("lat c%0d ValidD", i), {31'b0, ValidD}, 32'd1);
            chk($sformatf("lat c%0d InstrD", i), InstrD, 32'hA0 + n);
            chk($sformatf("lat c%0d PCPlus8D", i), PCPlus8D, 32'd8 + 32'd4 * n);
         end else begin
            chk($sformatf("lat c%0d ValidD", i), {31'b0, ValidD}, 32'd0);
            chk($sformatf("lat c%0d InstrD", i), InstrD, NOP);
         end
      end

      // branch redirect while the request to 0x10 is outstanding
      clearInputs();
      lat = 32'd0;
      doReset();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (imem_req && imem_addr == 32'h10) begin
            lat = 32'd5;
            found = 1'b1;
         end else begin
            @(negedge clk);
            #1;
         end
      end
      if (!found) timeoutFail("br reach 0x10");
      @(negedge clk);
      BranchTakenD = 1'b1; BranchTargetD = 32'h100; FlushD = 1'b1;
      #1;
      chk("br outstanding addr", imem_addr, 32'h10);
      chk("br outstanding req", {31'b0, imem_req}, 32'd1);
      @(negedge clk);
      clearInputs();
      #1;
      chk("br addr held after redirect", imem_addr, 32'h10);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (imem_ack) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      if (!got) timeoutFail("br stale ack");
      @(negedge clk);
      #1;
      chk("br next req", {31'b0, imem_req}, 32'd1);
      chk("br next addr", imem_addr, 32'h100);
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         if (ValidD) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      if (!got) timeoutFail("br first valid");
      else begin
         chk("br first InstrD", InstrD, 32'hE0);
         chk("br first PCPlus8D", PCPlus8D, 32'h108);
      end

      // PCSrcW wins over BranchTakenD; low bits of target forced to zero
      clearInputs();
      lat = 32'd0;
      StallF = 1'b1;
      doReset();
      PCSrcW = 1'b1; ResultW = 32'h203; BranchTakenD = 1'b1; BranchTargetD = 32'h100;
      #1;
      chk("prio redirect-cycle req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      clearInputs();
      #1;
      chk("prio next req", {31'b0, imem_req}, 32'd1);
      chk("prio next addr", imem_addr, 32'h200);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (ValidD) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      if (!got) timeoutFail("prio first valid");
      else begin
         chk("prio first InstrD", InstrD, 32'h120);
         chk("prio first PCPlus8D", PCPlus8D, 32'h208);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
